aes_encrypt_core: RTL and testbench

- Iterative AES block cipher (FIPS-197), encryption direction only. Performs one round per clock.
- Parameterised for AES-128, AES-192 or AES-256 at elaboration time.
- Standalone datapath block: a controller starts it with a single-cycle start pulse and collects the ciphertext on a valid pulse.

---
 rtl/aes_encrypt_core.sv | 166 ++++++++++++++++
 tb/tb_aes_encrypt_core.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_core.sv
// Iterative AES encryption core (128/192/256-bit keys), one round per clock.
// The full key schedule is expanded combinationally from the latched key register.
module aes_mix_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_i;
  assign col_o = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module aes_encrypt_core #(
  parameter int KEY_BITS = 128,
  parameter int NR       = 10,
  parameter int NK       = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [127:0]        in_i,
  input  logic [KEY_BITS-1:0] key_i,
  output logic [127:0]        out_o,
  output logic                busy_o,
  output logic                valid_o
);
  localparam int NW = 4 * (NR + 1);
  localparam int RW = $clog2(NR + 1);
  localparam logic [RW-1:0] LAST = RW'(NR);

  // Entry x sits at bits [2047-8x -: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    case (j)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_RUN} st_e;

  st_e                st_q, st_d;
  logic [RW-1:0]      rnd_q, rnd_d;
  logic [127:0]       state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [127:0]       out_q, out_d;
  logic               valid_q, valid_d;

  logic [31:0]  w [0:NW-1];
  logic [127:0] rkeys [0:NR];
  logic [31:0]  tmp;
  logic [127:0] sb, sr, mc, rk, rnd_res;

  always_comb begin
    tmp = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w[i] = key_q[KEY_BITS-1-32*i -: 32];
      end else begin
        tmp = w[i-1];
        if (i % NK == 0)
          tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rcon(i / NK), 24'h0};
        else if (NK > 6 && i % NK == 4)
          tmp = subword(tmp);
        w[i] = w[i-NK] ^ tmp;
      end
    end
    for (int r = 0; r <= NR; r++)
      rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

  // SubBytes then ShiftRows: new byte 4c+r comes from column (c+r)%4 of row r
  always_comb begin
    sb = '0;
    sr = '0;
    for (int b = 0; b < 16; b++)
      sb[127-8*b -: 8] = sbox(state_q[127-8*b -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_mix_col u_mc (.col_i(sr[127-32*c -: 32]), .col_o(mc[127-32*c -: 32]));
  end

  assign rk      = rkeys[rnd_q];
  assign rnd_res = ((rnd_q == LAST) ? sr : mc) ^ rk;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= S_IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      key_q   <= key_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    key_d   = key_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (st_q)
      S_IDLE: if (start_i) begin
        st_d    = S_RUN;
        key_d   = key_i;
        state_d = in_i ^ key_i[KEY_BITS-1 -: 128];
        rnd_d   = RW'(1);
      end
      S_RUN: begin
        state_d = rnd_res;
        rnd_d   = rnd_q + 1'b1;
        if (rnd_q == LAST) begin
          st_d    = S_IDLE;
          rnd_d   = '0;
          out_d   = rnd_res;
          valid_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (st_q == S_RUN);
    out_o   = out_q;
    valid_o = valid_q;
  end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: AES-128/192/256 instances share stimulus and are
// checked against a byte-level FIPS-197 model plus the published vectors.
module tb_aes_encrypt_core;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] din;
  logic [255:0] key;
  logic [127:0] dout [3];
  logic         dvld [3];
  logic         dbusy [3];
  int           cyc = 0;
  int           checks = 0, errors = 0;

  typedef struct {int inst; int cyc; logic [127:0] data;} pulse_t;
  pulse_t     pq[$];
  logic [7:0] sb_tab [256];

  localparam logic [127:0] P_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K_C  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (dvld[k] === 1'b1) begin
        pulse_t p;
        p.inst = k; p.cyc = cyc; p.data = dout[k];
        pq.push_back(p);
      end

  aes_encrypt_core #(.KEY_BITS(128), .NR(10), .NK(4)) u128 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_i(din), .key_i(key[255:128]),
    .out_o(dout[0]), .busy_o(dbusy[0]), .valid_o(dvld[0]));
  aes_encrypt_core #(.KEY_BITS(192), .NR(12), .NK(6)) u192 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_i(din), .key_i(key[255:64]),
    .out_o(dout[1]), .busy_o(dbusy[1]), .valid_o(dvld[1]));
  aes_encrypt_core #(.KEY_BITS(256), .NR(14), .NK(8)) u256 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_i(din), .key_i(key),
    .out_o(dout[2]), .busy_o(dbusy[2]), .valid_o(dvld[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from multiplicative inverse plus affine transform
  function automatic void init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb_tab[x[31:24]], sb_tab[x[23:16]], sb_tab[x[15:8]], sb_tab[x[7:0]]};
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [255:0] kk, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6; rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = kk[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8];
    for (int b = 0; b < 16; b++) s[b] ^= w[b/4][31-8*(b%4) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int b = 0; b < 16; b++) s[b] = sb_tab[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int b = 0; b < 16; b++) s[b] = t[b];
      if (rd < nr)
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(2, t[4*c]) ^ gmul(3, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(2, t[4*c+1]) ^ gmul(3, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(2, t[4*c+2]) ^ gmul(3, t[4*c+3]);
          s[4*c+3] = gmul(3, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(2, t[4*c+3]);
        end
      for (int b = 0; b < 16; b++) s[b] ^= w[4*rd + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic int nr_of(input int k);
    return 10 + 2*k;
  endfunction

  function automatic int nk_of(input int k);
    return 4 + 2*k;
  endfunction

  function automatic logic [127:0] kat_c(input int k);
    case (k)
      0: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      1: return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  // ---------------- pulse log queries ----------------
  function automatic int n_pulses(input int k, input int lo, input int hi);
    int n = 0;
    foreach (pq[i]) if (pq[i].inst == k && pq[i].cyc >= lo && pq[i].cyc <= hi) n++;
    return n;
  endfunction

  function automatic logic [127:0] pulse_at(input int k, input int c);
    logic [127:0] r = 'x;
    foreach (pq[i]) if (pq[i].inst == k && pq[i].cyc == c) r = pq[i].data;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_blk(input logic [127:0] p, input logic [255:0] k, output int e);
    start = 1'b1; din = p; key = k;
    @(posedge clk); #1;
    e = cyc;
    start = 1'b0; din = rnd128(); key = {rnd128(), rnd128()};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din = '0; key = '0;
    tick(2);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dout[k] !== 128'h0) begin errors++; $display("FAIL reset_out inst%0d got %h want 0", k, dout[k]); end
      checks++; if (dvld[k] !== 1'b0) begin errors++; $display("FAIL reset_valid inst%0d got %b want 0", k, dvld[k]); end
      checks++; if (dbusy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy inst%0d got %b want 0", k, dbusy[k]); end
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_kat();
    int e;
    logic [127:0] got, exp;
    start_blk(P_C, K_C, e);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dbusy[k] !== 1'b1) begin errors++; $display("FAIL kat_busy inst%0d got %b want 1", k, dbusy[k]); end
    end
    tick(16);
    for (int k = 0; k < 3; k++) begin
      got = pulse_at(k, e + nr_of(k));
      exp = ref_aes(P_C, K_C, nk_of(k));
      checks++; if (got !== kat_c(k)) begin errors++; $display("FAIL kat_vector inst%0d got %h want %h", k, got, kat_c(k)); end
      checks++; if (got !== exp) begin errors++; $display("FAIL kat_model inst%0d got %h want %h", k, got, exp); end
      checks++; if (n_pulses(k, e, e + 16) != 1) begin errors++; $display("FAIL kat_pulses inst%0d got %0d want 1", k, n_pulses(k, e, e + 16)); end
    end
    start_blk(128'h3243f6a8885a308d313198a2e0370734, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, e);
    tick(16);
    got = pulse_at(0, e + 10);
    checks++; if (got !== 128'h3925841d02dc09fbdc118597196a0b32) begin errors++; $display("FAIL appb_vector got %h want 3925841d02dc09fbdc118597196a0b32", got); end
    checks++; if (dout[0] !== 128'h3925841d02dc09fbdc118597196a0b32 || dvld[0] !== 1'b0) begin errors++; $display("FAIL appb_hold got %h/%b want 3925841d02dc09fbdc118597196a0b32/0", dout[0], dvld[0]); end
    for (int k = 1; k < 3; k++) begin
      exp = ref_aes(128'h3243f6a8885a308d313198a2e0370734, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, nk_of(k));
      got = pulse_at(k, e + nr_of(k));
      checks++; if (got !== exp) begin errors++; $display("FAIL appb_model inst%0d got %h want %h", k, got, exp); end
    end
  endtask

  task automatic test_ignore_start();
    int e;
    logic [127:0] got;
    start_blk(P_C, K_C, e);
    tick(4);
    start = 1'b1; din = rnd128(); key = {rnd128(), rnd128()};
    tick(1);
    start = 1'b0;
    tick(12);
    for (int k = 0; k < 3; k++) begin
      got = pulse_at(k, e + nr_of(k));
      checks++; if (got !== kat_c(k)) begin errors++; $display("FAIL ignore_out inst%0d got %h want %h", k, got, kat_c(k)); end
      checks++; if (n_pulses(k, e, cyc) != 1) begin errors++; $display("FAIL ignore_pulses inst%0d got %0d want 1", k, n_pulses(k, e, cyc)); end
    end
  endtask

  task automatic test_back_to_back();
    int e, e2;
    logic [127:0] p1, p2, got, exp;
    logic [255:0] k1, k2;
    p1 = rnd128(); k1 = {rnd128(), rnd128()};
    p2 = rnd128(); k2 = {rnd128(), rnd128()};
    start_blk(p1, k1, e);
    tick(10);
    checks++; if (dvld[0] !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", dvld[0]); end
    start_blk(p2, k2, e2);
    checks++; if (e2 != e + 11) begin errors++; $display("FAIL b2b_edge got %0d want %0d", e2, e + 11); end
    tick(16);
    exp = ref_aes(p1, k1, 4); got = pulse_at(0, e + 10);
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_first got %h want %h", got, exp); end
    exp = ref_aes(p2, k2, 4); got = pulse_at(0, e2 + 10);
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_second got %h want %h", got, exp); end
    checks++; if (n_pulses(0, e, cyc) != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", n_pulses(0, e, cyc)); end
    for (int k = 1; k < 3; k++) begin
      exp = ref_aes(p1, k1, nk_of(k)); got = pulse_at(k, e + nr_of(k));
      checks++; if (got !== exp) begin errors++; $display("FAIL b2b_busy_inst inst%0d got %h want %h", k, got, exp); end
      checks++; if (n_pulses(k, e, cyc) != 1) begin errors++; $display("FAIL b2b_busy_pulses inst%0d got %0d want 1", k, n_pulses(k, e, cyc)); end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    logic [127:0] p, got, exp;
    logic [255:0] kk;
    start_blk(rnd128(), {rnd128(), rnd128()}, e);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dout[k] !== 128'h0 || dbusy[k] !== 1'b0 || dvld[k] !== 1'b0) begin
        errors++; $display("FAIL midrst_state inst%0d got out=%h busy=%b valid=%b want 0/0/0", k, dout[k], dbusy[k], dvld[k]);
      end
    end
    tick(20);
    for (int k = 0; k < 3; k++) begin
      checks++; if (n_pulses(k, e, cyc) != 0) begin errors++; $display("FAIL midrst_pulses inst%0d got %0d want 0", k, n_pulses(k, e, cyc)); end
    end
    p = rnd128(); kk = {rnd128(), rnd128()};
    start_blk(p, kk, e);
    tick(16);
    for (int k = 0; k < 3; k++) begin
      exp = ref_aes(p, kk, nk_of(k)); got = pulse_at(k, e + nr_of(k));
      checks++; if (got !== exp) begin errors++; $display("FAIL midrst_after inst%0d got %h want %h", k, got, exp); end
    end
  endtask

  task automatic test_random();
    int e;
    logic [127:0] p, got, exp;
    logic [255:0] kk;
    for (int n = 0; n < 6; n++) begin
      p = rnd128(); kk = {rnd128(), rnd128()};
      start_blk(p, kk, e);
      tick(15);
      for (int k = 0; k < 3; k++) begin
        exp = ref_aes(p, kk, nk_of(k)); got = pulse_at(k, e + nr_of(k));
        checks++; if (got !== exp) begin errors++; $display("FAIL random%0d inst%0d got %h want %h", n, k, got, exp); end
        checks++; if (dout[k] !== exp) begin errors++; $display("FAIL random_hold%0d inst%0d got %h want %h", n, k, dout[k], exp); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = '0; key = '0;
    init_sbox();
    test_reset();
    test_kat();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
